// File: rtl/jx2_mem_arbiter.sv
// jx2_mem_arbiter
// Shares the single memory tile between the L1 I-cache and L1 D-cache miss
// ports. One requester owns the tile at a time and keeps it for the whole
// transaction, until it drops its op mode back to READY.
//
// Build option: define JX2_MEMARB_ROUNDROBIN_EN to replace the default
// I-side priority (with D-side starvation limit) by round-robin arbitration
// on contention. Ports and latency are the same in both builds.
//
// OK status encoding on icOK/dcOK/memOK: READY=0, OK=1, HOLD=2, FAULT=3.
// Op mode 0 means READY (no request) on every opm port.

module jx2_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clock,
  input  logic         reset,

  input  logic [47:0]  icAddr,
  input  logic [4:0]   icOpm,
  output logic [127:0] icDataO,
  output logic [1:0]   icOK,

  input  logic [47:0]  dcAddr,
  input  logic [4:0]   dcOpm,
  input  logic [127:0] dcDataI,
  output logic [127:0] dcDataO,
  output logic [1:0]   dcOK,

  output logic [47:0]  memAddr,
  output logic [4:0]   memOpm,
  output logic [127:0] memDataO,
  input  logic [127:0] memDataI,
  input  logic [1:0]   memOK,

  output logic [1:0]   arbOwner
);

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_HOLD  = 2'd2;

  localparam logic [3:0] STARVE_SAT = 4'hF;

`ifndef JX2_MEMARB_ROUNDROBIN_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
`endif

  // State encoding doubles as the arbOwner trace code (00 none, 01 I, 10 D).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arbState_t;

  arbState_t  state;
  arbState_t  pickState;
  logic [3:0] starve;
  logic       icReq;
  logic       dcReq;
  logic       dWins;

`ifdef JX2_MEMARB_ROUNDROBIN_EN
  // High when the most recent grant went to the D side.
  logic       lastOwnerD;
`endif

  assign icReq = |icOpm;
  assign dcReq = |dcOpm;

  // Decide who would win if arbitration happened this cycle; only used in IDLE.
  always_comb begin
    dWins     = 1'b0;
    pickState = IDLE;
`ifdef JX2_MEMARB_ROUNDROBIN_EN
    dWins = dcReq && (!icReq || !lastOwnerD);
`else
    dWins = dcReq && (!icReq || (starve >= STARVE_LIM));
`endif
    if (dWins) begin
      pickState = GNT_D;
    end else if (icReq) begin
      pickState = GNT_I;
    end else begin
      pickState = IDLE;
    end
  end

  // Main FSM: grant from IDLE, hold while the owner's opm stays nonzero, then fall back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state <= pickState;
        end
        GNT_I: begin
          if (!icReq) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (!dcReq) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Starvation counter: counts I grants handed out while D was left waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if ((pickState == GNT_D) || !dcReq) begin
        starve <= '0;
      end else if ((pickState == GNT_I) && (starve != STARVE_SAT)) begin
        starve <= starve + 4'd1;
      end
    end
  end

`ifdef JX2_MEMARB_ROUNDROBIN_EN
  // Remember the side that got the last grant so contention alternates.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastOwnerD <= 1'b1;
    end else if (state == IDLE) begin
      if (pickState == GNT_I) begin
        lastOwnerD <= 1'b0;
      end else if (pickState == GNT_D) begin
        lastOwnerD <= 1'b1;
      end
    end
  end
`endif

  // Port steering from the current owner; reset forces every output to its idle value.
  always_comb begin
    memAddr  = '0;
    memOpm   = '0;
    memDataO = '0;
    icDataO  = '0;
    dcDataO  = '0;
    icOK     = OK_READY;
    dcOK     = OK_READY;
    arbOwner = 2'b00;
    if (!reset) begin
      arbOwner = state;
      case (state)
        IDLE: begin
          icOK = icReq ? OK_HOLD : OK_READY;
          dcOK = dcReq ? OK_HOLD : OK_READY;
        end
        GNT_I: begin
          memAddr = icAddr;
          memOpm  = icOpm;
          icOK    = memOK;
          icDataO = memDataI;
          dcOK    = dcReq ? OK_HOLD : OK_READY;
        end
        GNT_D: begin
          memAddr  = dcAddr;
          memOpm   = dcOpm;
          memDataO = dcDataI;
          dcOK     = memOK;
          dcDataO  = memDataI;
          icOK     = icReq ? OK_HOLD : OK_READY;
        end
        default: begin
          arbOwner = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jx2_mem_arbiter.sv
// tb_jx2_mem_arbiter
// Randomised and directed stimulus for jx2_mem_arbiter, compared every cycle
// against a behavioural owner/starvation model kept in the bench.
// Honours JX2_MEMARB_ROUNDROBIN_EN the same way the design does.

module tb_jx2_mem_arbiter;

  localparam int STARVE_MAX = 4;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [47:0]  icAddr = '0;
  logic [4:0]   icOpm = '0;
  logic [127:0] icDataO;
  logic [1:0]   icOK;
  logic [47:0]  dcAddr = '0;
  logic [4:0]   dcOpm = '0;
  logic [127:0] dcDataI = '0;
  logic [127:0] dcDataO;
  logic [1:0]   dcOK;
  logic [47:0]  memAddr;
  logic [4:0]   memOpm;
  logic [127:0] memDataO;
  logic [127:0] memDataI = '0;
  logic [1:0]   memOK = '0;
  logic [1:0]   arbOwner;

  int checks = 0;
  int errors = 0;

  // Model state: owner 0 none / 1 I / 2 D.
  int mOwner = 0;
  int mStarve = 0;
  int mLastD = 1;

  bit         logEn = 1'b0;
  logic [1:0] prevOwn = 2'b00;
  int         grantLog[$];
  int         expLog[10];

  jx2_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .icAddr(icAddr), .icOpm(icOpm), .icDataO(icDataO), .icOK(icOK),
    .dcAddr(dcAddr), .dcOpm(dcOpm), .dcDataI(dcDataI), .dcDataO(dcDataO), .dcOK(dcOK),
    .memAddr(memAddr), .memOpm(memOpm), .memDataO(memDataO),
    .memDataI(memDataI), .memOK(memOK), .arbOwner(arbOwner)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] iop, input logic [4:0] dop,
                               input logic [1:0] mok);
    @(posedge clock);
    #1;
    reset  = r;
    icOpm  = iop;
    dcOpm  = dop;
    memOK  = mok;
  endtask

  // Behavioural model: who owns the tile after each edge, from the arbitration rules.
  always @(posedge clock) begin : modelProc
    bit icR;
    bit dcR;
    int win;
    icR = (icOpm != 5'd0);
    dcR = (dcOpm != 5'd0);
    win = 0;
    if (reset) begin
      mOwner = 0;
      mStarve = 0;
      mLastD = 1;
    end else if (mOwner == 0) begin
`ifdef JX2_MEMARB_ROUNDROBIN_EN
      if (icR && dcR) win = (mLastD != 0) ? 1 : 2;
      else if (icR)   win = 1;
      else if (dcR)   win = 2;
`else
      if (dcR && (!icR || mStarve >= STARVE_MAX)) win = 2;
      else if (icR) win = 1;
`endif
      if (win == 2 || !dcR) mStarve = 0;
      else if (win == 1) mStarve = (mStarve >= 15) ? 15 : mStarve + 1;
      if (win != 0) mLastD = (win == 2) ? 1 : 0;
      mOwner = win;
    end else if (mOwner == 1 && !icR) begin
      mOwner = 0;
    end else if (mOwner == 2 && !dcR) begin
      mOwner = 0;
    end
  end

  // Compare every DUT output against what the model says it must be.
  always @(negedge clock) begin : compareProc
    logic [47:0]  eAddr;
    logic [4:0]   eOpm;
    logic [127:0] eMemD;
    logic [127:0] eIcD;
    logic [127:0] eDcD;
    logic [1:0]   eIcOK;
    logic [1:0]   eDcOK;
    logic [1:0]   eOwn;
    eAddr = '0; eOpm = '0; eMemD = '0; eIcD = '0; eDcD = '0;
    eIcOK = ST_READY; eDcOK = ST_READY; eOwn = 2'b00;
    if (!reset) begin
      eOwn  = 2'(mOwner);
      eIcOK = (icOpm != 5'd0) ? ST_HOLD : ST_READY;
      eDcOK = (dcOpm != 5'd0) ? ST_HOLD : ST_READY;
      if (mOwner == 1) begin
        eAddr = icAddr; eOpm = icOpm; eIcOK = memOK; eIcD = memDataI;
      end else if (mOwner == 2) begin
        eAddr = dcAddr; eOpm = dcOpm; eMemD = dcDataI; eDcOK = memOK; eDcD = memDataI;
      end
    end
    checkOutput("memAddr",  128'(memAddr),  128'(eAddr));
    checkOutput("memOpm",   128'(memOpm),   128'(eOpm));
    checkOutput("memDataO", memDataO,       eMemD);
    checkOutput("icDataO",  icDataO,        eIcD);
    checkOutput("dcDataO",  dcDataO,        eDcD);
    checkOutput("icOK",     128'(icOK),     128'(eIcOK));
    checkOutput("dcOK",     128'(dcOK),     128'(eDcOK));
    checkOutput("arbOwner", 128'(arbOwner), 128'(eOwn));
  end

  // Record the order in which grants are handed out during the contention phase.
  always @(negedge clock) begin
    if (logEn && arbOwner != 2'b00 && prevOwn == 2'b00) grantLog.push_back(int'(arbOwner));
    prevOwn = arbOwner;
  end

  initial begin
`ifdef JX2_MEMARB_ROUNDROBIN_EN
    expLog = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`else
    expLog = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`endif
    $display("[TB] start");

    // Reset
    repeat (3) applyStimulus(1'b1, 5'd0, 5'd0, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    @(negedge clock);
    checkOutput("lit_rst_owner", 128'(arbOwner), 128'(2'b00));
    checkOutput("lit_rst_icOK",  128'(icOK),     128'(ST_READY));

    // I-side read alone at 0x1000
    icAddr = 48'h1000;
    applyStimulus(1'b0, 5'd1, 5'd0, ST_READY);
    @(negedge clock);
    checkOutput("lit_t1_idle_hold", 128'(icOK),   128'(ST_HOLD));
    checkOutput("lit_t1_idle_opm",  128'(memOpm), 128'(5'd0));
    applyStimulus(1'b0, 5'd1, 5'd0, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_t1_owner", 128'(arbOwner), 128'(2'b01));
    checkOutput("lit_t1_opm",   128'(memOpm),   128'(5'd1));
    checkOutput("lit_t1_addr",  128'(memAddr),  128'(48'h1000));
    repeat (2) applyStimulus(1'b0, 5'd1, 5'd0, ST_HOLD);
    memDataI = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    applyStimulus(1'b0, 5'd1, 5'd0, ST_OK);
    @(negedge clock);
    checkOutput("lit_t1_ok",   128'(icOK), 128'(ST_OK));
    checkOutput("lit_t1_data", icDataO,    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    @(negedge clock);
    checkOutput("lit_t1_rel_opm", 128'(memOpm), 128'(5'd0));
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    @(negedge clock);
    checkOutput("lit_t1_idle", 128'(arbOwner), 128'(2'b00));

    // D-side store alone
    dcAddr  = 48'h2000;
    dcDataI = {4{32'hA5A5_A5A5}};
    applyStimulus(1'b0, 5'd0, 5'd2, ST_HOLD);
    applyStimulus(1'b0, 5'd0, 5'd2, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_st_owner", 128'(arbOwner), 128'(2'b10));
    checkOutput("lit_st_opm",   128'(memOpm),   128'(5'd2));
    checkOutput("lit_st_data",  memDataO,       {4{32'hA5A5_A5A5}});
    applyStimulus(1'b0, 5'd0, 5'd2, ST_OK);
    @(negedge clock);
    checkOutput("lit_st_ok",   128'(dcOK), 128'(ST_OK));
    checkOutput("lit_st_icOK", 128'(icOK), 128'(ST_READY));
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);

    // Simultaneous requests: I first, D after one IDLE cycle
    applyStimulus(1'b0, 5'd1, 5'd2, ST_HOLD);
    applyStimulus(1'b0, 5'd1, 5'd2, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_sim_owner", 128'(arbOwner), 128'(2'b01));
    checkOutput("lit_sim_dcOK",  128'(dcOK),     128'(ST_HOLD));
    applyStimulus(1'b0, 5'd1, 5'd2, ST_OK);
    applyStimulus(1'b0, 5'd0, 5'd2, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd2, ST_READY);
    @(negedge clock);
    checkOutput("lit_sim_gap",  128'(arbOwner), 128'(2'b00));
    applyStimulus(1'b0, 5'd0, 5'd2, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_sim_dgnt", 128'(arbOwner), 128'(2'b10));
    applyStimulus(1'b0, 5'd0, 5'd2, ST_OK);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);

    // Continuous contention: each owner releases right after being granted
    logEn = 1'b1;
    repeat (20) begin
      @(posedge clock);
      #1;
      icOpm = (mOwner == 1) ? 5'd0 : 5'd1;
      dcOpm = (mOwner == 2) ? 5'd0 : 5'd3;
      memOK = ST_OK;
    end
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    logEn = 1'b0;
    checkOutput("lit_grant_count", 128'(grantLog.size() >= 10), 128'(1'b1));
    for (int i = 0; i < 10 && i < grantLog.size(); i++)
      checkOutput($sformatf("lit_grant_%0d", i), 128'(grantLog[i]), 128'(expLog[i]));

    // Reset in the middle of a D grant
    applyStimulus(1'b0, 5'd0, 5'd3, ST_HOLD);
    applyStimulus(1'b0, 5'd0, 5'd3, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_rg_owner", 128'(arbOwner), 128'(2'b10));
    applyStimulus(1'b1, 5'd0, 5'd3, ST_HOLD);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_rg_idle", 128'(arbOwner), 128'(2'b00));
    checkOutput("lit_rg_opm",  128'(memOpm),   128'(5'd0));
    checkOutput("lit_rg_dcOK", 128'(dcOK),     128'(ST_READY));
    checkOutput("lit_rg_icOK", 128'(icOK),     128'(ST_READY));

    // Abort: owner drops opm while tile still says HOLD
    applyStimulus(1'b0, 5'd4, 5'd0, ST_HOLD);
    applyStimulus(1'b0, 5'd4, 5'd0, ST_HOLD);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_HOLD);
    @(negedge clock);
    checkOutput("lit_ab_opm",  128'(memOpm), 128'(5'd0));
    checkOutput("lit_ab_icOK", 128'(icOK),   128'(ST_HOLD));
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    @(negedge clock);
    checkOutput("lit_ab_idle", 128'(arbOwner), 128'(2'b00));

    // Random traffic, occasional resets
    repeat (600) begin
      @(posedge clock);
      #1;
      reset    = ($urandom_range(0, 63) == 0);
      icOpm    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dcOpm    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      memOK    = 2'($urandom_range(0, 3));
      icAddr   = {16'($urandom), $urandom};
      dcAddr   = {16'($urandom), $urandom};
      dcDataI  = {$urandom, $urandom, $urandom, $urandom};
      memDataI = {$urandom, $urandom, $urandom, $urandom};
    end
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    applyStimulus(1'b0, 5'd0, 5'd0, ST_READY);
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
